// File: rtl/bm_seq_divide_if.sv
// Handshake/result bundle for the sequential divider.
//   master : the requester -- drives start and both operands, observes status/results
//   slave  : the divider   -- consumes the request, drives busy/done and the results
// Signals:
//   start        request pulse, only looked at while the divider is idle
//   dividend_in  unsigned dividend, captured with an accepted start
//   divisor_in   unsigned divisor, captured with an accepted start
//   busy         high while quotient bits are being retired
//   done         one-cycle completion pulse
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered with the quotient; set when the captured divisor was 0
interface bm_seq_divide_if #(
  parameter int BITS = 8
);
  logic            start;
  logic [BITS-1:0] dividend_in;
  logic [BITS-1:0] divisor_in;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output start, dividend_in, divisor_in,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend_in, divisor_in,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/bm_seq_divide.sv
// Multi-cycle unsigned restoring divider. One quotient bit is retired per
// clock, MSB first; results are registered on the last step and announced
// by a one-cycle done pulse.
// Ports:
//   clock    single clock, all state changes on posedge
//   reset_n  asynchronous active-low reset; clears every register
//   bus      bm_seq_divide_if.slave -- start/operands in, busy/done/results out
module bm_seq_divide #(
  parameter int BITS = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  bm_seq_divide_if.slave  bus
);

  localparam int CNT_W = (BITS > 2) ? $clog2(BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;

  logic [BITS:0]   pr_r;          // partial remainder, one guard bit
  logic [BITS-1:0] dvd_r;         // dividend, shifted out MSB first
  logic [BITS-1:0] dvs_r;         // captured divisor
  logic [BITS-1:0] qw_r;          // quotient bits collected so far
  logic [CNT_W-1:0] cnt_r;
  logic [BITS-1:0] quotient_r;
  logic [BITS-1:0] remainder_r;
  logic            dbz_r;

  logic [BITS+1:0] step;
  logic            q_bit;
  logic [BITS:0]   pr_nxt;
  logic            last_step;

  // One restoring iteration: bring in the next dividend bit, trial-subtract
  // the divisor and keep the difference only if it did not go negative.
  // Returns {quotient_bit, next_partial_remainder}.
  function automatic logic [BITS+1:0] restore_step(
    input logic [BITS:0]   pr,
    input logic            din,
    input logic [BITS-1:0] dvs
  );
    logic [BITS:0] trial;
    logic [BITS:0] diff;
    trial = {pr[BITS-1:0], din};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) return {1'b1, diff};
    else                      return {1'b0, trial};
  endfunction

  assign step      = restore_step(pr_r, dvd_r[BITS-1], dvs_r);
  assign q_bit     = step[BITS+1];
  assign pr_nxt    = step[BITS:0];
  assign last_step = (state == S_RUN) && (cnt_r == LAST_STEP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pr_r        <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      qw_r        <= '0;
      cnt_r       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        dvd_r <= bus.dividend_in;
        dvs_r <= bus.divisor_in;
        pr_r  <= '0;
        qw_r  <= '0;
        cnt_r <= '0;
      end else if (state == S_RUN) begin
        pr_r  <= pr_nxt;
        dvd_r <= {dvd_r[BITS-2:0], 1'b0};
        qw_r  <= {qw_r[BITS-2:0], q_bit};
        // Counter holds at its final value so it never wraps mid-operation.
        if (!last_step) cnt_r <= cnt_r + CNT_W'(1);
        if (last_step) begin
          quotient_r  <= {qw_r[BITS-2:0], q_bit};
          remainder_r <= pr_nxt[BITS-1:0];
          dbz_r       <= (dvs_r == '0);
        end
      end
    end
  end

  assign bus.busy        = (state == S_RUN);
  assign bus.done        = (state == S_DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule
